spi_slave_ctrl: RTL and testbench
=================================

Name: spi_slave_ctrl

Overview:
Serial front-end controller for the SPI slave with single-port RAM. Sequences frame reception on MOSI with an internal down-counting bit counter and presents completed 10-bit command/data words to the RAM. For read-data commands it waits for the RAM's read byte and shifts it out on MISO. SCK is the system clock `clk`; `ss_n` frames each transaction.

Parameters:
DATA_WIDTH, 8, RAM word/address width; the received frame is DATA_WIDTH+2 bits (2-bit command + payload).

Ports:
clk  input  1  system clock (SPI SCK); all logic on rising edge
rstn  input  1  synchronous active-low reset
ss_n  input  1  slave select, active low; high aborts/ends the transaction
mosi  input  1  serial data in, MSB first
miso  output  1  serial data out, MSB first; registered
rx_data  output  DATA_WIDTH+2  received frame; [9:8] is the command
rx_valid  output  1  one-cycle strobe: rx_data holds a complete new frame
tx_data  input  DATA_WIDTH  read byte from RAM
tx_valid  input  1  tx_data valid strobe from RAM

Behaviour:
- Reset (rstn=0 at a clk edge, from any state, mid-frame included): state=IDLE, miso=0, rx_data=0, rx_valid=0, rd_addr_seen=0, bit counter=0, shift registers=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. rd_addr_seen is an internal flag.
- IDLE: when ss_n=0 is sampled, go to CHK_CMD.
- CHK_CMD: sample mosi as frame bit 9 into the shift register, then load the bit counter with DATA_WIDTH.
  - mosi=0: go to WRITE.
  - mosi=1 and rd_addr_seen=0: go to READ_ADD.
  - mosi=1 and rd_addr_seen=1: go to READ_DATA.
- Receive phase (all three active states): each cycle, shift mosi in MSB-first and decrement the counter.
  - On the edge that samples the bit with counter==0 (10th frame bit), load rx_data={shift[8:0],mosi} and set rx_valid=1 for exactly one cycle.
  - Latency: the frame's first bit is sampled 1 edge after ss_n is seen low; rx_valid rises on the 10th sampling edge.
  - After the frame completes, further MOSI bits are ignored until ss_n rises. rx_data holds its value until the next completed frame.
- WRITE: no further action after rx_valid. The RAM decodes commands 00 (write address) and 01 (write data).
- READ_ADD: set rd_addr_seen=1 on the same edge as rx_valid.
- READ_DATA, after rx_valid:
  - Wait for tx_valid; wait indefinitely while ss_n=0. tx_valid seen in any other state or phase is ignored.
  - On the edge sampling tx_valid=1, capture tx_data and load the counter with DATA_WIDTH-1.
  - For the next DATA_WIDTH cycles, miso drives tx_data[7], then [6], down to [0], one bit per edge, counter decrementing.
  - On the edge after bit 0: miso=0, rd_addr_seen cleared. Then idle in state until ss_n rises.
  - A second tx_valid during or after shifting is ignored.
- ss_n=1 sampled in any non-IDLE state: go to IDLE on that edge.
  - miso=0; counter and shift registers cleared.
  - No rx_valid for a partial frame; an rx_valid issued on the same edge is suppressed.
  - rd_addr_seen is retained, so an aborted read-data transaction does not clear it.
- Counter width: $clog2(DATA_WIDTH+1). The counter never wraps; it is only reloaded on CHK_CMD exit or on tx_valid capture.
- miso=0 whenever not actively shifting.

Test Plan:
- Reset mid-frame: drive rstn=0 after 4 frame bits, then send a full frame -> outputs zeroed at reset; the next frame yields exactly one rx_valid with correct data.
- Write address: ss_n low, mosi = 00_1010_0101 -> rx_valid pulses once on the 10th sampling edge with rx_data=10'h0A5; state WRITE; miso stays 0; ss_n high -> IDLE next edge.
- Read sequence:
  - Send 10_0011_1100 -> rx_data=10'h23C and rd_addr_seen=1; raise ss_n.
  - Send 11_0000_0000 -> state READ_DATA and rx_valid with 10'h300.
  - Pulse tx_valid with tx_data=8'hC3 -> miso = 1,1,0,0,0,0,1,1 on the 8 following edges, then 0; rd_addr_seen=0.
- Read data without a prior read address: rd_addr_seen=0, send 11_xxxx_xxxx -> routed to READ_ADD (not READ_DATA) and rd_addr_seen set.
- Abort: ss_n rises after 6 bits of a write frame -> IDLE, no rx_valid; a following full frame 01_1111_0000 yields rx_data=10'h1F0.
- Abort during MISO shift: ss_n rises after 3 bits of 8'hC3 -> miso=0 and IDLE; rd_addr_seen stays 1; stray tx_valid in IDLE or WRITE is ignored.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_ctrl
// Brief   : SPI slave front end. Receives command/data frames on MOSI and
//           returns RAM read bytes on MISO.
// Rev     : 1.0  initial release
// ============================================================================
module spi_slave_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH+1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid
);

    localparam int c_CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHK_CMD   = 3'd1,
        S_WRITE     = 3'd2,
        S_READ_ADD  = 3'd3,
        S_READ_DATA = 3'd4
    } state_t;

    // Sub-phase within an active state: receiving, waiting for RAM, shifting out.
    typedef enum logic [2:0] {
        P_RX    = 3'd0,
        P_WAIT  = 3'd1,
        P_SHIFT = 3'd2,
        P_TAIL  = 3'd3,
        P_DONE  = 3'd4
    } phase_t;

    state_t                r_state;
    phase_t                r_phase;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH:0]   r_rx_sr;
    logic [DATA_WIDTH-1:0] r_tx_sr;
    logic                  r_rd_addr_seen;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_phase        <= P_RX;
            r_cnt          <= '0;
            r_rx_sr        <= '0;
            r_tx_sr        <= '0;
            r_rd_addr_seen <= 1'b0;
            miso           <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            // Deselect wins over everything, including a frame completing now.
            if (r_state != S_IDLE && ss_n) begin
                r_state <= S_IDLE;
                r_phase <= P_RX;
                r_cnt   <= '0;
                r_rx_sr <= '0;
                r_tx_sr <= '0;
                miso    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_phase <= P_RX;
                        if (!ss_n)
                            r_state <= S_CHK_CMD;
                    end
                    S_CHK_CMD: begin
                        r_rx_sr <= {r_rx_sr[DATA_WIDTH-1:0], mosi};
                        r_cnt   <= c_CNT_W'(DATA_WIDTH);
                        r_phase <= P_RX;
                        if (!mosi)
                            r_state <= S_WRITE;
                        else if (!r_rd_addr_seen)
                            r_state <= S_READ_ADD;
                        else
                            r_state <= S_READ_DATA;
                    end
                    default: begin
                        case (r_phase)
                            P_RX: begin
                                r_rx_sr <= {r_rx_sr[DATA_WIDTH-1:0], mosi};
                                if (r_cnt == '0) begin
                                    rx_data  <= {r_rx_sr, mosi};
                                    rx_valid <= 1'b1;
                                    if (r_state == S_READ_ADD)
                                        r_rd_addr_seen <= 1'b1;
                                    r_phase <= (r_state == S_READ_DATA) ? P_WAIT : P_DONE;
                                end else begin
                                    r_cnt <= r_cnt - 1'b1;
                                end
                            end
                            P_WAIT: begin
                                if (tx_valid) begin
                                    r_tx_sr <= tx_data;
                                    r_cnt   <= c_CNT_W'(DATA_WIDTH - 1);
                                    r_phase <= P_SHIFT;
                                end
                            end
                            P_SHIFT: begin
                                miso    <= r_tx_sr[DATA_WIDTH-1];
                                r_tx_sr <= r_tx_sr << 1;
                                if (r_cnt == '0)
                                    r_phase <= P_TAIL;
                                else
                                    r_cnt <= r_cnt - 1'b1;
                            end
                            P_TAIL: begin
                                miso           <= 1'b0;
                                r_rd_addr_seen <= 1'b0;
                                r_phase        <= P_DONE;
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave_ctrl
// Brief   : Directed, table-driven bench for spi_slave_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spi_slave_ctrl;

    localparam int DW = 8;
    localparam int ST_IDLE = 0, ST_WRITE = 2, ST_READ_ADD = 3, ST_READ_DATA = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ss_n;
    logic          mosi;
    logic          miso;
    logic [DW+1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;

    int n_checks = 0;
    int n_fail   = 0;

    spi_slave_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0] frame;
        logic [9:0] exp_data;
        int         exp_state;
        logic       exp_seen;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Assert ss_n, then drive nbits of f MSB first; samples #1 after each edge.
    task automatic send_bits(input logic [9:0] f, input int nbits,
                             output int nval, output int vedge,
                             output logic [9:0] cap, output int miso_hi);
        nval = 0; vedge = -1; cap = '0; miso_hi = 0;
        @(negedge clk);
        ss_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < nbits; i++) begin
            mosi = f[9-i];
            @(posedge clk); #1;
            if (rx_valid) begin nval++; vedge = i; cap = rx_data; end
            if (miso) miso_hi++;
        end
    endtask

    // Full frame plus two trailing bits that must be ignored.
    task automatic frame_chk(input logic [9:0] f, input logic [9:0] exp_d,
                             input int exp_st, input logic exp_seen);
        int nval, vedge, mh;
        logic [9:0] cap;
        send_bits(f, 10, nval, vedge, cap, mh);
        for (int j = 0; j < 2; j++) begin
            mosi = ~mosi;
            @(posedge clk); #1;
            if (rx_valid) nval++;
            if (miso) mh++;
        end
        check("rx_valid_count", nval, 1);
        check("rx_valid_edge", vedge, 9);
        check("rx_data", int'(cap), int'(exp_d));
        check("rx_data_hold", int'(rx_data), int'(exp_d));
        check("state", int'(dut.r_state), exp_st);
        check("rd_addr_seen", int'(dut.r_rd_addr_seen), int'(exp_seen));
        check("miso_idle", mh, 0);
    endtask

    task automatic end_txn();
        @(negedge clk);
        ss_n = 1'b1;
        @(posedge clk); #1;
        check("ss_high_idle", int'(dut.r_state), ST_IDLE);
        check("ss_high_miso", int'(miso), 0);
    endtask

    // Pulse tx_valid with byte b, then check nb MISO bits MSB first.
    task automatic tx_shift(input logic [7:0] b, input int nb);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check("miso_at_capture", int'(miso), 0);
        for (int k = 0; k < nb; k++) begin
            @(posedge clk); #1;
            check("miso_bit", int'(miso), int'(b[7-k]));
        end
    endtask

    initial begin
        int nval, vedge, mh;
        logic [9:0] cap;
        logic [9:0] prev;

        vecs[0] = '{10'b00_1010_0101, 10'h0A5, ST_WRITE,     1'b0};
        vecs[1] = '{10'b01_1111_0000, 10'h1F0, ST_WRITE,     1'b0};
        vecs[2] = '{10'b10_0011_1100, 10'h23C, ST_READ_ADD,  1'b1};
        vecs[3] = '{10'b00_0000_0001, 10'h001, ST_WRITE,     1'b1};
        vecs[4] = '{10'b11_0000_0000, 10'h300, ST_READ_DATA, 1'b1};
        vecs[5] = '{10'b11_1111_1111, 10'h3FF, ST_READ_DATA, 1'b1};

        rstn = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_data = '0; tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_miso", int'(miso), 0);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_state", int'(dut.r_state), ST_IDLE);
        rstn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            frame_chk(vecs[v].frame, vecs[v].exp_data, vecs[v].exp_state, vecs[v].exp_seen);
            end_txn();
        end

        // Reset in the middle of a frame, with rd_addr_seen currently set.
        send_bits(10'b11_0101_0101, 4, nval, vedge, cap, mh);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("midrst_state", int'(dut.r_state), ST_IDLE);
        check("midrst_rx_data", int'(rx_data), 0);
        check("midrst_rx_valid", int'(rx_valid), 0);
        check("midrst_seen", int'(dut.r_rd_addr_seen), 0);
        check("midrst_cnt", int'(dut.r_cnt), 0);
        check("midrst_miso", int'(miso), 0);
        rstn = 1'b1;
        ss_n = 1'b1;
        @(posedge clk); #1;
        frame_chk(10'b00_0101_0101, 10'h055, ST_WRITE, 1'b0);
        end_txn();

        // Read address then read data with byte C3 shifted out.
        frame_chk(10'b10_0011_1100, 10'h23C, ST_READ_ADD, 1'b1);
        end_txn();
        frame_chk(10'b11_0000_0000, 10'h300, ST_READ_DATA, 1'b1);
        tx_shift(8'hC3, 8);
        @(posedge clk); #1;
        check("miso_after_byte", int'(miso), 0);
        check("seen_cleared", int'(dut.r_rd_addr_seen), 0);
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        mh = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (miso) mh++;
        end
        check("second_tx_ignored", mh, 0);
        end_txn();

        // Read-data command without prior read address goes to READ_ADD.
        frame_chk(10'b11_1010_1010, 10'h3AA, ST_READ_ADD, 1'b1);
        end_txn();

        // Abort partway through shifting out a byte.
        frame_chk(10'b11_0000_0000, 10'h300, ST_READ_DATA, 1'b1);
        tx_shift(8'hC3, 3);
        end_txn();
        check("abort_shift_seen", int'(dut.r_rd_addr_seen), 1);

        // Stray tx_valid in IDLE and throughout a write frame.
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(posedge clk); #1;
        check("stray_idle_miso", int'(miso), 0);
        frame_chk(10'b00_1100_0011, 10'h0C3, ST_WRITE, 1'b1);
        tx_valid = 1'b0;
        end_txn();

        // Abort a write frame after 6 bits, then a full frame.
        send_bits(10'b00_1111_1111, 6, nval, vedge, cap, mh);
        end_txn();
        check("abort6_no_valid", nval + int'(rx_valid), 0);
        frame_chk(10'b01_1111_0000, 10'h1F0, ST_WRITE, 1'b1);
        end_txn();

        // Deselect on the very edge that would complete the frame.
        prev = rx_data;
        send_bits(10'b01_0000_1111, 9, nval, vedge, cap, mh);
        mosi = 1'b1;
        ss_n = 1'b1;
        @(posedge clk); #1;
        check("abort10_no_valid", nval + int'(rx_valid), 0);
        check("abort10_idle", int'(dut.r_state), ST_IDLE);
        check("abort10_rx_hold", int'(rx_data), int'(prev));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
